// File: rtl/lm_sm_sequencer.sv
// ============================================================================
// Module   : lm_sm_sequencer
// Purpose  : Multi-cycle sequencer for LM/SM/LA/SA register-list transfers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lm_sm_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        load,
   input  logic        sig_multiple,
   input  logic        sig_all,
   input  logic [7:0]  reg_list,
   input  logic [15:0] base_addr,
   input  logic        mem_ready,
   output logic [15:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [2:0]  reg_addr,
   output logic        reg_write,
   output logic        stall,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  mask, mask_nxt;
   logic [15:0] addr_cnt, addr_nxt;
   logic        dir, dir_nxt;
   logic [2:0]  low_idx;
   logic [7:0]  low_bit;
   logic [7:0]  accept_mask;
   logic        accept;

   // Lowest set bit wins: scan from the top so the last hit is the lowest.
   always_comb begin
      low_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i]) low_idx = 3'(i);
      end
   end

   assign low_bit     = 8'd1 << low_idx;
   assign accept_mask = sig_all ? 8'hFF : reg_list;
   assign accept      = (state == IDLE) & start & (sig_multiple | sig_all) & ~reset;

   always_comb begin
      state_nxt = state;
      mask_nxt  = mask;
      addr_nxt  = addr_cnt;
      dir_nxt   = dir;
      mem_addr  = 16'h0000;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_addr  = 3'd0;
      reg_write = 1'b0;
      stall     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               mask_nxt  = accept_mask;
               addr_nxt  = base_addr;
               dir_nxt   = load;
               stall     = 1'b1;
               state_nxt = (accept_mask != 8'h00) ? XFER : DONE;
            end
         end
         XFER: begin
            busy      = 1'b1;
            stall     = 1'b1;
            mem_addr  = addr_cnt;
            mem_read  = dir;
            mem_write = ~dir;
            reg_addr  = low_idx;
            if (mem_ready) begin
               mask_nxt  = mask & ~low_bit;
               addr_nxt  = addr_cnt + 16'd1;
               reg_write = dir;
               if ((mask & ~low_bit) == 8'h00) state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            stall     = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Outputs read as zero for the whole reset cycle, even mid-transfer.
      if (reset) begin
         mem_addr  = 16'h0000;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         reg_addr  = 3'd0;
         reg_write = 1'b0;
         stall     = 1'b0;
         busy      = 1'b0;
         done      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         mask     <= 8'h00;
         addr_cnt <= 16'h0000;
         dir      <= 1'b0;
      end else begin
         state    <= state_nxt;
         mask     <= mask_nxt;
         addr_cnt <= addr_nxt;
         dir      <= dir_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lm_sm_sequencer.sv
// ============================================================================
// Module   : tb_lm_sm_sequencer
// Purpose  : Directed scoreboard bench for lm_sm_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lm_sm_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, load, sig_multiple, sig_all, mem_ready;
   logic [7:0]  reg_list;
   logic [15:0] base_addr;
   logic [15:0] mem_addr;
   logic        mem_read, mem_write, reg_write, stall, busy, done;
   logic [2:0]  reg_addr;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      bit          dn;
      logic [15:0] a;
      logic [2:0]  r;
      bit          d;
   } exp_t;
   exp_t q[$];

   lm_sm_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .load(load),
      .sig_multiple(sig_multiple), .sig_all(sig_all), .reg_list(reg_list),
      .base_addr(base_addr), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_read(mem_read), .mem_write(mem_write), .reg_addr(reg_addr),
      .reg_write(reg_write), .stall(stall), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({mem_addr, mem_read, mem_write, reg_addr, reg_write, stall, busy, done});
   endfunction

   // Scoreboard monitor: every completed access and every done pulse pops one entry.
   always @(negedge clk) begin
      exp_t e;
      chk("rw_gate", 32'(reg_write), 32'(mem_read & mem_ready));
      if ((mem_read | mem_write) && mem_ready) begin
         if (q.size() == 0) chk("unexpected_access", 32'(mem_addr), 32'hFFFF_FFFF);
         else begin
            e = q.pop_front();
            chk("acc_kind", 32'(e.dn), 32'd0);
            chk("acc_addr", 32'(mem_addr), 32'(e.a));
            chk("acc_reg",  32'(reg_addr), 32'(e.r));
            chk("acc_dir",  32'({mem_read, mem_write, reg_write}), 32'({e.d, ~e.d, e.d}));
         end
      end
      if (done) begin
         if (q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
         else begin
            e = q.pop_front();
            chk("done_kind", 32'(e.dn), 32'd1);
            chk("done_strobes", 32'({mem_read, mem_write}), 32'd0);
         end
      end
   end

   task automatic push_xfer(input bit ld, input logic [7:0] msk, input logic [15:0] base);
      exp_t e;
      logic [15:0] a;
      a = base;
      for (int i = 0; i < 8; i++) begin
         if (msk[i]) begin
            e.dn = 1'b0; e.a = a; e.r = 3'(i); e.d = ld;
            q.push_back(e);
            a = a + 16'd1;
         end
      end
      e.dn = 1'b1; e.a = 16'h0; e.r = 3'd0; e.d = 1'b0;
      q.push_back(e);
   endtask

   task automatic wait_done(input string tag, input int exp_cyc);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) chk({tag, "_timeout"}, 32'(cyc), 32'(exp_cyc));
      else       chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
   endtask

   task automatic run_op(input bit ld, input bit m, input bit a, input logic [7:0] lst,
                         input logic [15:0] base, input string tag);
      int n, k;
      logic [7:0] msk;
      msk = a ? 8'hFF : lst;
      k   = $countones(msk);
      push_xfer(ld, msk, base);
      @(posedge clk); #1;
      start = 1'b1; load = ld; sig_multiple = m; sig_all = a;
      reg_list = lst; base_addr = base;
      @(negedge clk);
      n = cyc;
      chk({tag, "_acc_stall"}, 32'({stall, busy}), 32'b10);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(tag, n + k + 1);
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b1; load = 1'b1; sig_multiple = 1'b0; sig_all = 1'b1;
      reg_list = 8'h00; base_addr = 16'h0000; mem_ready = 1'b1;

      // Reset with start high: outputs zero, reset wins.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", outs(), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0; sig_all = 1'b0;
      @(negedge clk);
      chk("reset_prio", outs(), 32'd0);

      run_op(1'b1, 1'b1, 1'b0, 8'hA5, 16'h0100, "lm_a5");
      run_op(1'b0, 1'b0, 1'b1, 8'h00, 16'hFFFE, "sa_wrap");
      run_op(1'b0, 1'b1, 1'b0, 8'h00, 16'h1234, "sm_empty");
      @(negedge clk);
      chk("sm_empty_idle_stall", 32'({stall, busy}), 32'd0);

      // Start without a select is ignored.
      @(posedge clk); #1;
      start = 1'b1; sig_multiple = 1'b0; sig_all = 1'b0; reg_list = 8'hFF;
      @(negedge clk);
      chk("nosel_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("nosel_busy", 32'(busy), 32'd0);

      // Memory wait on first access.
      push_xfer(1'b1, 8'h03, 16'h0040);
      @(posedge clk); #1;
      mem_ready = 1'b0; start = 1'b1; load = 1'b1; sig_multiple = 1'b1;
      reg_list = 8'h03; base_addr = 16'h0040;
      @(negedge clk);
      n = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wait_hold", 32'({mem_addr, reg_addr, mem_read, reg_write}),
             32'({16'h0040, 3'd0, 1'b1, 1'b0}));
      end
      @(posedge clk); #1;
      mem_ready = 1'b1;
      wait_done("lm_wait", n + 6);

      // Reset during the 2nd access of LA.
      push_xfer(1'b1, 8'h01, 16'h0200);
      void'(q.pop_back());
      @(posedge clk); #1;
      start = 1'b1; load = 1'b1; sig_multiple = 1'b0; sig_all = 1'b1; base_addr = 16'h0200;
      @(negedge clk);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_during", outs(), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_after", outs(), 32'd0);
      end
      run_op(1'b0, 1'b1, 1'b0, 8'h81, 16'h0300, "post_reset");

      // Start during XFER is ignored.
      push_xfer(1'b1, 8'h03, 16'h0500);
      @(posedge clk); #1;
      start = 1'b1; load = 1'b1; sig_multiple = 1'b1; sig_all = 1'b0;
      reg_list = 8'h03; base_addr = 16'h0500;
      @(negedge clk);
      n = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      start = 1'b1; load = 1'b0; sig_all = 1'b1; base_addr = 16'h0700;
      @(negedge clk);
      chk("midxfer_busy", 32'({stall, busy, mem_addr}), 32'({2'b11, 16'h0501}));
      @(posedge clk); #1;
      start = 1'b0; sig_all = 1'b0;
      wait_done("midxfer", n + 3);
      @(negedge clk);
      chk("midxfer_idle", 32'(busy), 32'd0);

      run_op(1'b1, 1'b1, 1'b1, 8'h00, 16'h0800, "both_sel");

      repeat (4) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset sampled on the rising clk edge.
REQ-003 SHALL have port start, input, 1, request to run a multiple-transfer instruction.
REQ-004 SHALL have port load, input, 1, 1 = load (LM/LA), 0 = store (SM/SA).
REQ-005 SHALL have port sig_multiple, input, 1, LM/SM select; the register list governs the transfer.
REQ-006 SHALL have port sig_all, input, 1, LA/SA select; all eight registers are transferred.
REQ-007 SHALL have port reg_list, input, 8, register mask from imm[7:0]; bit i selects Ri.
REQ-008 SHALL have port base_addr, input, 16, starting memory word address (value of Ra).
REQ-009 SHALL have port mem_ready, input, 1, memory completes the current access this cycle.
REQ-010 SHALL have port mem_addr, output, 16, address of the current access.
REQ-011 SHALL have port mem_read and port mem_write, outputs, 1 each, access strobes.
REQ-012 SHALL have port reg_addr, output, 3, register index being read (store) or written (load).
REQ-013 SHALL have port reg_write, output, 1, register-file write enable for load data.
REQ-014 SHALL have port stall, output, 1, freezes upstream pipeline stages.
REQ-015 SHALL have port busy, output, 1, high when the sequencer is not IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, XFER and DONE.
REQ-018 In IDLE, start & (sig_multiple | sig_all) SHALL be accepted: mask <= sig_all ? 8'hFF : reg_list; addr_cnt <= base_addr; dir <= load.
REQ-019 sig_all SHALL take priority when sig_multiple and sig_all are both high.
REQ-020 start with sig_multiple = sig_all = 0, and start while not IDLE, SHALL be ignored.
REQ-021 After acceptance, the next state SHALL be XFER if mask != 0, otherwise DONE; no memory access occurs for an empty mask.
REQ-022 In XFER: reg_addr = index of the lowest set mask bit; mem_addr = addr_cnt; mem_read = dir; mem_write = ~dir; all held stable until mem_ready.
REQ-023 In XFER with mem_ready = 1: clear that mask bit; addr_cnt <= addr_cnt + 1, modulo 2^16 (0xFFFF wraps to 0x0000); reg_write = dir in that same cycle.
REQ-024 reg_write SHALL be 0 whenever it is not asserted under REQ-023.
REQ-025 XFER SHALL go to DONE on the mem_ready cycle that clears the last mask bit; otherwise it SHALL remain in XFER.
REQ-026 In DONE: done = 1 for exactly one cycle, no strobes, then go to IDLE; a new start SHALL be accepted no earlier than the following IDLE cycle.
REQ-027 busy SHALL equal (state != IDLE).
REQ-028 stall SHALL equal busy | (IDLE & accepted start); stall is combinational, so the pipeline freezes in the acceptance cycle.
REQ-029 Latency: with mem_ready tied high and k set bits, accept at cycle N, strobes at N+1..N+k, done at N+k+1; with k = 0, done at N+1.
REQ-030 With mem_ready low, XFER SHALL hold indefinitely without changing mask or addr_cnt.

Reset
REQ-031 On reset: state = IDLE, mask = 0, addr_cnt = 0, dir = 0.
REQ-032 During and after reset, all outputs SHALL be 0 (mem_addr = 16'h0000, reg_addr = 3'b000).
REQ-033 Reset mid-XFER SHALL abort the transfer in the next cycle, with no further strobes and no done pulse.
REQ-034 reset SHALL take priority over start in the same cycle.

Verification
REQ-035 LM, reg_list = 8'b1010_0101, base = 16'h0100, mem_ready = 1 -> loads R0, R2, R5, R7 from 0x0100..0x0103, reg_write on each of those cycles, done at N+5.
REQ-036 SA, base = 16'hFFFE -> stores R0..R7 at 0xFFFE, 0xFFFF, 0x0000..0x0005, mem_write on 8 cycles, never mem_read, done at N+9.
REQ-037 SM, reg_list = 8'h00 -> no strobes, stall only in the acceptance cycle and the DONE cycle, done at N+1.
REQ-038 LM, reg_list = 8'h03, mem_ready low for 3 cycles on the first access -> mem_addr and reg_addr stable for 4 cycles, then R0 and R1 written, done after R1 is written.
REQ-039 reset asserted during the 2nd access of LA -> idle next cycle, all outputs 0, no done; a subsequent start is accepted normally.
REQ-040 start pulsed during XFER, plus sig_multiple = sig_all = 1 on acceptance -> the mid-transfer start is ignored; the accepted start transfers all 8 registers.
